// File: rtl/core85_pkg.sv
// core85_pkg -- shared constants for the 8085-style core control path.
//
// Holds the bit positions of the datapath enable vector (ienb) and of the
// decoded instruction info word (chk_i), plus the machine-cycle and T-state
// encodings used on the mcyc/tst outputs, including the HALT code.
package core85_pkg;

    // Width of the decoded instruction info word.
    localparam int CHK_W = 17;

    // ienb bit positions.
    localparam int IE_RRD = 0;
    localparam int IE_RWR = 1;
    localparam int IE_COD = 2;
    localparam int IE_EXT = 3;
    localparam int IE_PC  = 4;
    localparam int IE_PD  = 5;
    localparam int IE_NXT = 6;
    localparam int IE_W   = 7;

    // chk_i bit positions; the three 4-bit fields start at the _LO index
    // and are indexed by extra-cycle number (M2 -> +0 ... M5 -> +3).
    localparam int CK_GO6    = 0;
    localparam int CK_DAD    = 1;
    localparam int CK_HLT    = 2;
    localparam int CK_DIO    = 3;
    localparam int CK_EXT_LO = 4;
    localparam int CK_WR_LO  = 8;
    localparam int CK_DP_LO  = 12;
    localparam int CK_COND   = 16;

    // Machine-cycle encodings (mcyc output).
    localparam logic [2:0] MC_M1 = 3'd0;
    localparam logic [2:0] MC_M2 = 3'd1;
    localparam logic [2:0] MC_M3 = 3'd2;
    localparam logic [2:0] MC_M4 = 3'd3;
    localparam logic [2:0] MC_M5 = 3'd4;

    // T-state encodings (tst output); HALT shares the tst field.
    localparam logic [2:0] TS_T1   = 3'd0;
    localparam logic [2:0] TS_T2   = 3'd1;
    localparam logic [2:0] TS_T3   = 3'd2;
    localparam logic [2:0] TS_T4   = 3'd3;
    localparam logic [2:0] TS_T5   = 3'd4;
    localparam logic [2:0] TS_T6   = 3'd5;
    localparam logic [2:0] TS_HALT = 3'd7;

endpackage

// File: rtl/ctrlseq_cycsel.sv
// cycsel -- per-machine-cycle field select.
//
// Picks the write flag, data-pointer flag and continue flag that apply to the
// current machine cycle out of the latched instruction info fields.
//
// Ports:
//   info_i  in  12  chk bits [15:4]: [3:0] extra-cycle thermometer,
//                   [7:4] write flags, [11:8] data-pointer flags
//   mcyc_i  in  3   current machine cycle (M1..M5)
//   wr_o    out 1   current extra cycle is a write (0 in M1)
//   dp_o    out 1   current extra cycle uses the data pointer (0 in M1)
//   cont_o  out 1   another machine cycle follows this one (0 in M5)
module cycsel
    import core85_pkg::*;
(
    input  logic [11:0] info_i,
    input  logic [2:0]  mcyc_i,
    output logic        wr_o,
    output logic        dp_o,
    output logic        cont_o
);

    localparam int WO = CK_WR_LO - CK_EXT_LO;
    localparam int DO = CK_DP_LO - CK_EXT_LO;

    always_comb begin
        wr_o   = 1'b0;
        dp_o   = 1'b0;
        cont_o = 1'b0;
        case (mcyc_i)
            MC_M1: cont_o = info_i[0];
            MC_M2: begin
                wr_o   = info_i[WO];
                dp_o   = info_i[DO];
                cont_o = info_i[1];
            end
            MC_M3: begin
                wr_o   = info_i[WO + 1];
                dp_o   = info_i[DO + 1];
                cont_o = info_i[2];
            end
            MC_M4: begin
                wr_o   = info_i[WO + 2];
                dp_o   = info_i[DO + 2];
                cont_o = info_i[3];
            end
            MC_M5: begin
                // M5 is the last possible cycle: never continues.
                wr_o = info_i[WO + 3];
                dp_o = info_i[DO + 3];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrlseq.sv
// ctrlseq -- machine-cycle / T-state sequencer for the 8085-style core.
//
// Steps M1 opcode fetch (T1-T4, optionally T5-T6) and up to four extra
// machine cycles (T1-T3 each), then returns to M1 or parks in HALT. All
// outputs decode from registered state; chk_i is captured at the end of M1 T4
// and later decisions use that copy.
//
// Build option: define CTRLSEQ_WAIT_EN to let ready=0 in T2 insert wait
// states; without it ready is ignored.
//
// Ports:
//   clk    in  1   core clock, rising edge
//   rst_   in  1   asynchronous active-low reset
//   chk_i  in  17  decoded instruction info
//   ready  in  1   memory ready (T2 wait states when enabled)
//   ienb   out 7   datapath enables RRD,RWR,COD,EXT,PC_,PD_,NXT
//   rd_    out 1   active-low read strobe
//   wr_    out 1   active-low write strobe
//   ale    out 1   address latch enable
//   iom    out 1   IO (1) / memory (0) cycle
//   mcyc   out 3   machine cycle, 0..4 = M1..M5
//   tst    out 3   T-state, 0..5 = T1..T6, 7 = HALT
//   ccc_q  out 1   condition bit latched at M1 T4
//   halt   out 1   HALT state indicator
module ctrlseq
    import core85_pkg::*;
(
    input  logic             clk,
    input  logic             rst_,
    input  logic [CHK_W-1:0] chk_i,
    input  logic             ready,
    output logic [IE_W-1:0]  ienb,
    output logic             rd_,
    output logic             wr_,
    output logic             ale,
    output logic             iom,
    output logic [2:0]       mcyc,
    output logic [2:0]       tst,
    output logic             ccc_q,
    output logic             halt
);

    // run_q is clear while reset holds and for the edge that releases it,
    // so the reset image (ale=0) is distinct from the first running M1 T1.
    logic             run_q;
    logic [2:0]       mcyc_q, mcyc_d;
    logic [2:0]       tst_q, tst_d;
    logic [CHK_W-1:0] chk_q, chk_d;

    logic cs_wr, cs_dp, cs_cont;
    logic stall;
    logic end_cyc, cont, go_halt;
    logic idle, active;
    logic go6_unused;

    assign go6_unused = chk_q[CK_GO6];

`ifdef CTRLSEQ_WAIT_EN
    assign stall = ~ready;
`else
    logic ready_unused;
    assign ready_unused = ready;
    assign stall        = 1'b0;
`endif

    cycsel u_cycsel (
        .info_i (chk_q[CK_DP_LO+3:CK_EXT_LO]),
        .mcyc_i (mcyc_q),
        .wr_o   (cs_wr),
        .dp_o   (cs_dp),
        .cont_o (cs_cont)
    );

    always_comb begin
        mcyc_d  = mcyc_q;
        tst_d   = tst_q;
        chk_d   = chk_q;
        end_cyc = 1'b0;
        cont    = 1'b0;
        go_halt = 1'b0;
        if (run_q) begin
            case (tst_q)
                TS_T1: tst_d = TS_T2;
                TS_T2: if (!stall) tst_d = TS_T3;
                TS_T3: begin
                    if (mcyc_q == MC_M1) begin
                        tst_d = TS_T4;
                    end else begin
                        end_cyc = 1'b1;
                        cont    = cs_cont;
                        go_halt = chk_q[CK_HLT];
                    end
                end
                TS_T4: begin
                    // Decode point: the only place chk_i is looked at. The
                    // short-M1 decision uses the live word on the same edge.
                    chk_d = chk_i;
                    if (chk_i[CK_GO6]) begin
                        tst_d = TS_T5;
                    end else begin
                        end_cyc = 1'b1;
                        cont    = chk_i[CK_EXT_LO];
                        go_halt = chk_i[CK_HLT];
                    end
                end
                TS_T5: tst_d = TS_T6;
                TS_T6: begin
                    end_cyc = 1'b1;
                    cont    = cs_cont;
                    go_halt = chk_q[CK_HLT];
                end
                default: ;  // HALT (and unused code 6) hold until reset
            endcase
            if (end_cyc) begin
                if (cont && (mcyc_q != MC_M5)) begin
                    mcyc_d = mcyc_q + 3'd1;
                    tst_d  = TS_T1;
                end else if (go_halt) begin
                    mcyc_d = MC_M1;
                    tst_d  = TS_HALT;
                end else begin
                    mcyc_d = MC_M1;
                    tst_d  = TS_T1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            run_q  <= 1'b0;
            mcyc_q <= MC_M1;
            tst_q  <= TS_T1;
            chk_q  <= '0;
        end else begin
            run_q  <= 1'b1;
            mcyc_q <= mcyc_d;
            tst_q  <= tst_d;
            chk_q  <= chk_d;
        end
    end

    // DAD turns M2/M3 into bus-idle cycles.
    assign idle   = chk_q[CK_DAD] && ((mcyc_q == MC_M2) || (mcyc_q == MC_M3));
    assign active = run_q && (tst_q != TS_HALT);

    always_comb begin
        ienb = '0;
        rd_  = 1'b1;
        wr_  = 1'b1;
        ale  = 1'b0;
        iom  = 1'b0;
        if (active) begin
            if (mcyc_q == MC_M1) begin
                case (tst_q)
                    TS_T1: ale = 1'b1;
                    TS_T2: rd_ = 1'b0;
                    TS_T3: begin
                        rd_          = 1'b0;
                        ienb[IE_COD] = 1'b1;
                        ienb[IE_PC]  = 1'b1;
                    end
                    TS_T6: begin
                        // Register-pair update when no bus cycles follow.
                        if (chk_q[CK_EXT_LO +: 4] == 4'd0) begin
                            ienb[IE_EXT] = 1'b1;
                            ienb[IE_RWR] = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else begin
                ienb[IE_PD]  = cs_dp;
                ienb[IE_NXT] = (mcyc_q == MC_M3) || (mcyc_q == MC_M5);
                iom          = (mcyc_q == MC_M3) && chk_q[CK_DIO];
                if (idle) begin
                    if (tst_q == TS_T3) begin
                        ienb[IE_EXT] = 1'b1;
                        ienb[IE_RWR] = 1'b1;
                    end
                end else begin
                    case (tst_q)
                        TS_T1: ale = 1'b1;
                        TS_T2: begin
                            rd_ = cs_wr;
                            wr_ = ~cs_wr;
                        end
                        TS_T3: begin
                            rd_          = cs_wr;
                            wr_          = ~cs_wr;
                            ienb[IE_RWR] = cs_wr;
                            ienb[IE_RRD] = ~cs_wr;
                            ienb[IE_PC]  = ~cs_wr && ~cs_dp;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign mcyc  = mcyc_q;
    assign tst   = tst_q;
    assign ccc_q = chk_q[CK_COND];
    assign halt  = (tst_q == TS_HALT);

endmodule

// File: tb/tb_ctrlseq.sv
// tb_ctrlseq -- self-checking bench for ctrlseq.
//
// For each instruction word the bench writes out the expected clock-by-clock
// trace (one entry per clock) straight from the bus-cycle rules, then steps
// the DUT through it. Entries other than M1 T4 drive random junk on chk_i so
// only the decode point can influence the sequence.
module tb_ctrlseq;

    logic        clk = 1'b0;
    logic        rst_;
    logic        ready;
    logic [16:0] chk_i;
    logic [6:0]  ienb;
    logic        rd_, wr_, ale, iom, ccc_q, halt;
    logic [2:0]  mcyc, tst;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ctrlseq dut (
        .clk   (clk),
        .rst_  (rst_),
        .chk_i (chk_i),
        .ready (ready),
        .ienb  (ienb),
        .rd_   (rd_),
        .wr_   (wr_),
        .ale   (ale),
        .iom   (iom),
        .mcyc  (mcyc),
        .tst   (tst),
        .ccc_q (ccc_q),
        .halt  (halt)
    );

    typedef struct packed {
        logic [2:0]  m;
        logic [2:0]  t;
        logic [6:0]  ie;
        logic        rd;
        logic        wr;
        logic        al;
        logic        io;
        logic        hl;
        logic        cc;
        logic [16:0] drv;
    } ent_t;

    ent_t q[$];
    logic exp_ccc = 1'b0;

    function automatic logic [16:0] rnd();
        return 17'($urandom());
    endfunction

    task automatic push(input int m, input int t, input logic [6:0] ie,
                        input logic rd, input logic wr, input logic al,
                        input logic io, input logic hl, input logic [16:0] drv);
        ent_t e;
        e.m   = m[2:0];
        e.t   = t[2:0];
        e.ie  = ie;
        e.rd  = rd;
        e.wr  = wr;
        e.al  = al;
        e.io  = io;
        e.hl  = hl;
        e.cc  = exp_ccc;
        e.drv = drv;
        q.push_back(e);
    endtask

    // Expected trace of one instruction. ienb bits: RRD=1 RWR=2 COD=4 EXT=8
    // PC_=16 PD_=32 NXT=64.
    task automatic gen_instr(input logic [16:0] c, input int hclk);
        logic       dad, wrc, dp, io;
        logic [6:0] base, t3;
        int         i;
        q.delete();
        push(0, 0, 7'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, rnd());
        push(0, 1, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rnd());
        push(0, 2, 7'h14, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rnd());
        push(0, 3, 7'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, c);
        exp_ccc = c[16];
        if (c[0]) begin
            push(0, 4, 7'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, rnd());
            push(0, 5, (c[7:4] == 4'd0) ? 7'h0A : 7'h00,
                 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, rnd());
        end
        for (int k = 2; k <= 5; k++) begin
            if (!c[4 + k - 2]) break;
            i       = k - 2;
            dad     = c[1] && (k == 2 || k == 3);
            wrc     = c[8 + i];
            dp      = c[12 + i];
            io      = (k == 3) && c[3];
            base    = 7'h00;
            base[5] = dp;
            base[6] = (k == 3 || k == 5);
            if (dad) begin
                push(k - 1, 0, base, 1'b1, 1'b1, 1'b0, io, 1'b0, rnd());
                push(k - 1, 1, base, 1'b1, 1'b1, 1'b0, io, 1'b0, rnd());
                push(k - 1, 2, base | 7'h0A, 1'b1, 1'b1, 1'b0, io, 1'b0, rnd());
            end else begin
                t3 = base | (wrc ? 7'h02 : (dp ? 7'h01 : 7'h11));
                push(k - 1, 0, base, 1'b1, 1'b1, 1'b1, io, 1'b0, rnd());
                push(k - 1, 1, base, wrc, !wrc, 1'b0, io, 1'b0, rnd());
                push(k - 1, 2, t3, wrc, !wrc, 1'b0, io, 1'b0, rnd());
            end
        end
        if (c[2]) begin
            for (int h = 0; h < hclk; h++)
                push(0, 7, 7'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, rnd());
        end
    endtask

    // Steps the DUT through the trace of c. mode 0: ready always high;
    // 1: random low in T2 (at most 3 per instruction); 2: low for the first
    // 3 T2 clocks. Returns early, unclocked, on reaching M(stop_m+1) T(stop_t+1).
    task automatic run_instr(input logic [16:0] c, input int mode, input int hclk,
                             input int stop_m, input int stop_t);
        int          idx;
        int          stalls;
        bit          adv;
        ent_t        e;
        logic [18:0] act, exp;
        idx    = 0;
        stalls = 0;
        gen_instr(c, hclk);
        while (idx < q.size()) begin
            e   = q[idx];
            act = {mcyc, tst, ienb, rd_, wr_, ale, iom, halt, ccc_q};
            exp = {e.m, e.t, e.ie, e.rd, e.wr, e.al, e.io, e.hl, e.cc};
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL trace chk=%h step %0d (M%0d T%0d): got %h required %h",
                         c, idx, int'(e.m) + 1, int'(e.t) + 1, act, exp);
            end
            if (int'(e.m) == stop_m && int'(e.t) == stop_t) return;
            chk_i = e.drv;
            ready = 1'b1;
            adv   = 1'b1;
            if (e.t == 3'd1 && stalls < 3) begin
                if (mode == 2 || (mode == 1 && $urandom_range(0, 2) == 0)) begin
                    ready = 1'b0;
                    stalls++;
`ifdef CTRLSEQ_WAIT_EN
                    adv = 1'b0;
`endif
                end
            end
            @(posedge clk);
            #1;
            if (adv) idx++;
        end
    endtask

    task automatic check_reset_vals(input string name);
        logic [18:0] act;
        act = {mcyc, tst, ienb, rd_, wr_, ale, iom, halt, ccc_q};
        n_cmp++;
        if (act !== {3'd0, 3'd0, 7'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act,
                     {3'd0, 3'd0, 7'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_    = 1'b1;
        exp_ccc = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_  = 1'b0;
        ready = 1'b1;
        chk_i = 17'h1FFFF;
        #3;
        check_reset_vals("reset_initial");
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset_held_clocks");
        release_reset();
    endtask

    task automatic test_mov();
        for (int n = 0; n < 3; n++) run_instr(17'h00000, 0, 0, 9, 9);
    endtask

    task automatic test_mov_m();
        run_instr(17'h01110, 0, 0, 9, 9);
        run_instr(17'h10000, 0, 0, 9, 9);
    endtask

    task automatic test_dad();
        run_instr(17'h00033, 0, 0, 9, 9);
        run_instr(17'h00001, 0, 0, 9, 9);
    endtask

    task automatic test_wait();
        run_instr(17'h00000, 2, 0, 9, 9);
        run_instr(17'h00010, 2, 0, 9, 9);
    endtask

    task automatic test_halt();
        run_instr(17'h00014, 0, 20, 9, 9);
        #2;
        rst_ = 1'b0;
        #1;
        check_reset_vals("halt_exit_reset");
        release_reset();
        run_instr(17'h00000, 0, 0, 9, 9);
    endtask

    task automatic test_async_reset();
        // OUT: M2 read, M3 write with DIO; stop in M3 T2 and reset mid-cycle.
        run_instr(17'h00238, 0, 0, 2, 1);
        #2;
        rst_ = 1'b0;
        #1;
        check_reset_vals("async_reset_m3t2");
        release_reset();
        run_instr(17'h00000, 0, 0, 9, 9);
    endtask

    task automatic test_back_to_back();
        logic [16:0] c;
        for (int n = 0; n < 40; n++) begin
            c    = rnd();
            c[2] = 1'b0;
            run_instr(c, 1, 0, 9, 9);
        end
    endtask

    initial begin
        test_reset();
        test_mov();
        test_mov_m();
        test_dad();
        test_wait();
        test_halt();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
